// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for alu_control codes 1000-1111 (MUL..MULHU).
// Fixed XLEN+2 cycle latency from accept to done; start is ignored while busy, flush kills silently.
module muldiv_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            div_by_zero
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MULU  = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_REM   = 3'd4;
  localparam logic [2:0] OP_REMU  = 3'd5;
  localparam logic [2:0] OP_MULH  = 3'd6;
  localparam logic [2:0] OP_MULHU = 3'd7;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op;
  logic              op_div;
  logic              sign_a;
  logic              sign_b;
  logic              b_zero;
  logic              ovf;
  logic [XLEN-1:0]   a_lat;
  logic [XLEN-1:0]   addend;
  // multiply: {product_hi, multiplier/product_lo}; divide: {remainder, quotient}
  logic [2*XLEN-1:0] acc;

  logic              launch;
  logic              in_signed;
  logic              in_div;
  logic              in_sa;
  logic              in_sb;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;

  always_comb begin
    in_signed = ~alu_control[0];
    in_div    = (alu_control[2:0] >= OP_DIV) && (alu_control[2:0] <= OP_REMU);
    in_sa     = in_signed & operand_a[XLEN-1];
    in_sb     = in_signed & operand_b[XLEN-1];
    mag_a     = in_sa ? ('0 - operand_a) : operand_a;
    mag_b     = in_sb ? ('0 - operand_b) : operand_b;
    launch    = start & alu_control[3] & ((state == S_IDLE) || (state == S_DONE));
  end

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_diff;
  logic              div_borrow;
  logic [2*XLEN-1:0] acc_next;

  always_comb begin
    mul_sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? addend : {XLEN{1'b0}})};
    div_shift  = acc[2*XLEN-1:XLEN-1];
    div_diff   = {1'b0, div_shift} - {2'b00, addend};
    div_borrow = div_diff[XLEN+1];
    if (op_div) begin
      acc_next = {(div_borrow ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0]),
                  acc[XLEN-2:0], ~div_borrow};
    end else begin
      acc_next = {mul_sum, acc[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fin_result;

  // Sign flags are only ever set for signed ops, so unsigned results pass straight through.
  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? ('0 - acc) : acc;
    quot_fix = (sign_a ^ sign_b) ? ('0 - acc[XLEN-1:0]) : acc[XLEN-1:0];
    rem_fix  = sign_a ? ('0 - acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
    case (op)
      OP_MUL, OP_MULU:   fin_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHU: fin_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:   fin_result = b_zero ? '1 : (ovf ? a_lat : quot_fix);
      default:           fin_result = b_zero ? a_lat : (ovf ? '0 : rem_fix);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op          <= '0;
      op_div      <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      b_zero      <= 1'b0;
      ovf         <= 1'b0;
      a_lat       <= '0;
      addend      <= '0;
      acc         <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (launch) begin
            state  <= S_CALC;
            cnt    <= '0;
            op     <= alu_control[2:0];
            op_div <= in_div;
            sign_a <= in_sa;
            sign_b <= in_sb;
            b_zero <= (operand_b == '0);
            ovf    <= in_div & in_signed & (operand_a == INT_MIN) & (operand_b == '1);
            a_lat  <= operand_a;
            addend <= in_div ? mag_b : mag_a;
            acc    <= {{XLEN{1'b0}}, (in_div ? mag_a : mag_b)};
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(XLEN - 1)) begin
            state <= S_FINISH;
          end
        end
        S_FINISH: begin
          result      <= fin_result;
          div_by_zero <= b_zero & op_div;
          state       <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_CALC) || (state == S_FINISH);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases, flush/reset/ignore behaviour, random ops.
module tb_muldiv_unit;
  localparam int XLEN = 64;
  localparam int LAT  = XLEN + 2;

  localparam logic [3:0] C_MUL   = 4'b1000;
  localparam logic [3:0] C_MULU  = 4'b1001;
  localparam logic [3:0] C_DIV   = 4'b1010;
  localparam logic [3:0] C_DIVU  = 4'b1011;
  localparam logic [3:0] C_REM   = 4'b1100;
  localparam logic [3:0] C_REMU  = 4'b1101;
  localparam logic [3:0] C_MULH  = 4'b1110;
  localparam logic [3:0] C_MULHU = 4'b1111;

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  alu_control = 4'b0000;
  logic [63:0] operand_a = '0;
  logic [63:0] operand_b = '0;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        div_by_zero;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .alu_control (alu_control),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_checks = 0;
  int   n_pass = 0;
  int   done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [3:0] code, input logic [63:0] a, input logic [63:0] b);
    start       = 1'b1;
    alu_control = code;
    operand_a   = a;
    operand_b   = b;
    tick();
    start       = 1'b0;
    alu_control = 4'b0000;
  endtask

  task automatic issue(input logic [3:0] code, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] r, input logic z);
    sb.push_back('{res: r, dbz: z, cyc: cyc});
    drive_start(code, a, b);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("timeout_pending", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    tick();
  endtask

  function automatic logic [64:0] model(input logic [3:0] code, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] xa, xb, sp;
    logic [127:0]        up;
    logic signed [63:0]  sa, sbv, sq;
    xa  = $signed(a);
    xb  = $signed(b);
    sp  = xa * xb;
    up  = {64'd0, a} * {64'd0, b};
    sa  = $signed(a);
    sbv = $signed(b);
    case (code)
      C_MUL, C_MULU: return {1'b0, up[63:0]};
      C_MULH:        return {1'b0, sp[127:64]};
      C_MULHU:       return {1'b0, up[127:64]};
      C_DIV: begin
        if (b == 64'd0) return {1'b1, ALL1};
        if (a == MIN && b == ALL1) return {1'b0, MIN};
        sq = sa / sbv;
        return {1'b0, sq};
      end
      C_DIVU: return (b == 64'd0) ? {1'b1, ALL1} : {1'b0, a / b};
      C_REM: begin
        if (b == 64'd0) return {1'b1, a};
        if (a == MIN && b == ALL1) return 65'd0;
        sq = sa % sbv;
        return {1'b0, sq};
      end
      default: return (b == 64'd0) ? {1'b1, a} : {1'b0, a % b};
    endcase
  endfunction

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("spurious_done", {63'd0, done}, 64'd0);
      end else begin
        e_mon = sb.pop_front();
        check("result", result, e_mon.res);
        check("div_by_zero", {63'd0, div_by_zero}, {63'd0, e_mon.dbz});
        check("latency", 64'(cyc - e_mon.cyc), 64'(LAT));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int busy_hi;
    int d0;

    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // MUL 7 x -3 with busy window over cycles 1..65
    issue(C_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    busy_hi = 0;
    for (int i = 1; i <= LAT - 1; i++) begin
      @(negedge clk);
      if (busy) busy_hi++;
    end
    @(negedge clk);
    check("busy_cycles", 64'(busy_hi), 64'(LAT - 1));
    check("busy_in_done", {63'd0, busy}, 64'd0);
    check("done_cycle66", {63'd0, done}, 64'd1);
    wait_idle();

    issue(C_MULH,  ALL1, ALL1, 64'd0, 1'b0);                  wait_idle();
    issue(C_MULHU, ALL1, ALL1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0); wait_idle();
    issue(C_MULU,  ALL1, ALL1, 64'd1, 1'b0);                  wait_idle();
    issue(C_DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0); wait_idle();
    issue(C_REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ALL1, 1'b0); wait_idle();
    issue(C_DIVU, 64'd100, 64'd7, 64'd14, 1'b0);              wait_idle();
    issue(C_REMU, 64'd100, 64'd7, 64'd2, 1'b0);               wait_idle();

    // flush in cycle 30 of a DIV
    d0 = done_cnt;
    drive_start(C_DIV, 64'd1000, 64'd3);
    repeat (29) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_done", {63'd0, done}, 64'd0);
    check("flush_keep_result", result, 64'd2);
    check("flush_keep_dbz", {63'd0, div_by_zero}, 64'd0);
    repeat (LAT + 4) tick();
    check("flush_no_done", 64'(done_cnt - d0), 64'd0);

    // non-muldiv code is ignored
    drive_start(4'b0010, 64'd9, 64'd9);
    @(negedge clk);
    check("code0010_busy", {63'd0, busy}, 64'd0);
    repeat (LAT + 4) tick();
    check("code0010_no_done", 64'(done_cnt - d0), 64'd0);

    // start while busy must not disturb the op in flight
    issue(C_MUL, 64'd3, 64'd5, 64'd15, 1'b0);
    repeat (10) tick();
    drive_start(C_DIVU, 64'd9, 64'd3);
    wait_idle();
    repeat (LAT + 4) tick();
    check("busy_start_one_done", 64'(done_cnt - d0), 64'd1);

    issue(C_DIVU, 64'd5, 64'd0, ALL1, 1'b1);   wait_idle();
    issue(C_REM,  64'd5, 64'd0, 64'd5, 1'b1);  wait_idle();
    issue(C_DIV,  MIN, ALL1, MIN, 1'b0);       wait_idle();
    issue(C_REM,  MIN, ALL1, 64'd0, 1'b0);     wait_idle();

    // back-to-back: second start lands in the DONE cycle of the first
    issue(C_MUL, 64'd6, 64'd7, 64'd42, 1'b0);
    repeat (LAT - 1) tick();
    issue(C_MUL, 64'd3, 64'd4, 64'd12, 1'b0);
    wait_idle();

    // synchronous reset mid-CALC
    d0 = done_cnt;
    drive_start(C_MUL, 64'd7, 64'd3);
    repeat (20) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_result", result, 64'd0);
    check("midrst_dbz", {63'd0, div_by_zero}, 64'd0);
    repeat (LAT + 4) tick();
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);

    for (int i = 0; i < 12; i++) begin
      logic [3:0]  code;
      logic [63:0] a;
      logic [63:0] b;
      logic [64:0] m;
      code = 4'b1000 | 4'($urandom_range(0, 7));
      a    = {$urandom, $urandom};
      b    = (i % 3 == 0) ? 64'($urandom_range(0, 9)) : {$urandom, $urandom};
      if (i % 4 == 1) b = {32'd0, $urandom};
      if (i % 5 == 2) a = -a;
      m = model(code, a, b);
      issue(code, a, b, m[63:0], m[64]);
      wait_idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
